// File: rtl/evt_snapshot_reg_if.sv
// Purpose: bundles the run control, event and snapshot signals of evt_snapshot_reg.
// Latency: none, this is wiring only.
// Backpressure: none; the snapshot word is a level and the strobe is a one-cycle pulse.
// Ports (master = controller/reader, slave = evt_snapshot_reg):
//   en, evt_in, snap_req, period_cfg : master -> slave
//   user_data_out, snap_strobe       : slave  -> master
interface evt_snapshot_reg_if #(
    parameter int PERIOD_W = 24
);
    logic                en;
    logic                evt_in;
    logic [PERIOD_W-1:0] period_cfg;
    logic                snap_req;
    logic [31:0]         user_data_out;
    logic                snap_strobe;

    modport master (
        output en, evt_in, period_cfg, snap_req,
        input  user_data_out, snap_strobe
    );

    modport slave (
        input  en, evt_in, period_cfg, snap_req,
        output user_data_out, snap_strobe
    );
endinterface

// File: rtl/evt_snapshot_reg.sv
// Purpose: counts evt_in per interval of period_cfg+1 cycles and publishes {seq, sat, count} as a coherent word.
// Latency: an event in the closing cycle N is visible in user_data_out with snap_strobe high in cycle N+1.
// Backpressure: none; the reader must sample the word, which stays stable until the next snapshot.
// Ports:
//   user_clk, user_rst : clock and synchronous active-high reset
//   bus (slave)        : en, evt_in, period_cfg, snap_req in; user_data_out, snap_strobe out
module evt_snapshot_reg #(
    parameter int CNT_W    = 27,
    parameter int PERIOD_W = 24
) (
    input  logic               user_clk,
    input  logic               user_rst,
    evt_snapshot_reg_if.slave  bus
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [CNT_W-1:0] ACC_MAX = '1;

    state_t              r_state;
    logic [PERIOD_W-1:0] r_pcnt;
    logic [CNT_W-1:0]    r_acc;
    logic                r_sat;
    logic [3:0]          r_seq;
    logic [31:0]         r_dout;
    logic                r_strobe;

    logic                w_acc_full;
    logic [CNT_W-1:0]    w_acc_next;
    logic                w_sat_next;
    logic                w_snap;
    logic [3:0]          w_seq_next;
    logic [26:0]         w_cnt27;

    // The accumulator sticks at its maximum; an event arriving while full
    // is recorded only through the saturation flag.
    assign w_acc_full = (r_acc == ACC_MAX);
    assign w_acc_next = (bus.evt_in && !w_acc_full) ? r_acc + CNT_W'(1) : r_acc;
    assign w_sat_next = r_sat | (bus.evt_in & w_acc_full);

    // Exact equality: if period_cfg drops below the running counter, the
    // counter free-runs through its wrap before it can match again.
    assign w_snap     = (r_pcnt == bus.period_cfg) | bus.snap_req;
    assign w_seq_next = r_seq + 4'd1;
    assign w_cnt27    = 27'(w_acc_next);

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_state  <= S_IDLE;
            r_pcnt   <= '0;
            r_acc    <= '0;
            r_sat    <= 1'b0;
            r_seq    <= 4'd0;
            r_dout   <= 32'd0;
            r_strobe <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_pcnt   <= '0;
                    r_acc    <= '0;
                    r_sat    <= 1'b0;
                    r_strobe <= 1'b0;
                    if (bus.en) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!bus.en) begin
                        // Partial interval is dropped, published word untouched.
                        r_state  <= S_IDLE;
                        r_pcnt   <= '0;
                        r_acc    <= '0;
                        r_sat    <= 1'b0;
                        r_strobe <= 1'b0;
                    end else if (w_snap) begin
                        r_dout   <= {w_seq_next, w_sat_next, w_cnt27};
                        r_seq    <= w_seq_next;
                        r_pcnt   <= '0;
                        r_acc    <= '0;
                        r_sat    <= 1'b0;
                        r_strobe <= 1'b1;
                    end else begin
                        r_pcnt   <= r_pcnt + PERIOD_W'(1);
                        r_acc    <= w_acc_next;
                        r_sat    <= w_sat_next;
                        r_strobe <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_strobe <= 1'b0;
                end
            endcase
        end
    end

    assign bus.user_data_out = r_dout;
    assign bus.snap_strobe   = r_strobe;

endmodule

// File: doc/evt_snapshot_reg.md
EVT_SNAPSHOT_REG -- requirements
Module: evt_snapshot_reg

Interface
REQ-001 Parameter: CNT_W, default 27, width of the interval event counter; fixed at 27 so the packed word is 32 bits.
REQ-002 Parameter: PERIOD_W, default 24, width of the interval period configuration.
REQ-003 Port: user_clk  in  1  sole clock; all logic is rising-edge synchronous to it.
REQ-004 Port: user_rst  in  1  reset, synchronous and active-high.
REQ-005 Port: en  in  1  run enable; 1 = count and snapshot, 0 = idle.
REQ-006 Port: evt_in  in  1  event qualifier; each cycle with evt_in=1 counts one event.
REQ-007 Port: period_cfg  in  PERIOD_W  interval length minus one, in user_clk cycles.
REQ-008 Port: snap_req  in  1  single-cycle request to snapshot immediately.
REQ-009 Port: user_data_out  out  32  packed snapshot word; drives the user_data_in input of the downstream OPB software register.
REQ-010 Port: snap_strobe  out  1  one-cycle pulse, high in the first cycle a new user_data_out value is visible.

Function
REQ-011 user_data_out packing SHALL be: [31:28] snapshot sequence number, [27] saturation flag, [26:0] event count of the closed interval.
REQ-012 The block SHALL implement a two-state FSM: IDLE and RUN.
REQ-013 IDLE -> RUN SHALL occur on the first rising edge with en=1; RUN -> IDLE SHALL occur on the first rising edge with en=0.
REQ-014 In IDLE, the period counter, the event accumulator and the saturation flag SHALL be held at 0, user_data_out SHALL hold its last value, and snap_strobe SHALL be 0.
REQ-015 In RUN, the period counter SHALL increment by one per cycle from 0; the terminal condition is period counter == period_cfg.
REQ-016 In RUN, the snapshot condition SHALL be terminal OR snap_req; simultaneous terminal and snap_req SHALL produce exactly one snapshot.
REQ-017 On a snapshot edge:
  - user_data_out SHALL load {seq+1, sat, acc_next}, where acc_next includes any event in that same cycle;
  - the period counter and accumulator SHALL restart at 0;
  - snap_strobe SHALL be 1 in the following cycle only.
REQ-018 Latency: an event in cycle N that closes an interval SHALL be visible in user_data_out and flagged by snap_strobe in cycle N+1.
REQ-019 The accumulator SHALL saturate at 2^27-1; a further event while saturated SHALL set the interval's saturation flag and leave the count at 2^27-1.
REQ-020 The sequence number SHALL be 4 bits, incremented per snapshot, and wrap 15 -> 0.
REQ-021 period_cfg=0 SHALL give a snapshot every RUN cycle.
REQ-022 A period_cfg change mid-interval SHALL take effect at the next comparison; if the counter already exceeds the new value, the counter SHALL run to wrap (2^PERIOD_W-1 -> 0) before terminating, with no spurious snapshot.
REQ-023 en falling mid-interval SHALL discard the partial count without a snapshot; snap_req in IDLE SHALL be ignored.
REQ-024 user_data_out SHALL change only on snapshot edges or reset, so a software read always sees a coherent word.

Reset
REQ-025 While user_rst=1 on a rising edge, the block SHALL enter IDLE and SHALL clear user_data_out, snap_strobe, the sequence number, the period counter, the accumulator and the saturation flag to 0.
REQ-026 user_rst SHALL take priority over en, evt_in and snap_req in the same cycle.
REQ-027 Reset asserted mid-interval SHALL discard the partial count, and the first post-reset snapshot SHALL carry sequence number 1.

Verification
REQ-028 Scenario: period_cfg=9, en=1, evt_in=1 continuously -> snap_strobe every 10 cycles; user_data_out = 0x1000000A, then 0x2000000A, and so on.
REQ-029 Scenario: period_cfg=99, 3 events, snap_req in cycle 20 coincident with a 4th event -> user_data_out=0x10000004 at cycle 21; the next interval starts at 0.
REQ-030 Scenario: force the accumulator to 2^27-2, then apply 3 events before the terminal cycle -> user_data_out[27]=1 and [26:0]=0x7FFFFFF; the following interval has flag 0.
REQ-031 Scenario: 17 snapshots after reset -> sequence reads 1..15, 0, 1.
REQ-032 Scenario: en dropped at cycle 5 of 10 with 5 events -> no snap_strobe and user_data_out unchanged; after re-enable, the first snapshot counts only new events.
REQ-033 Scenario: user_rst pulsed mid-interval while snap_req=1 -> no snapshot, user_data_out=0, snap_strobe=0 in the next cycle.
